// File: rtl/audio_receive.sv
// I2S serial-to-parallel receiver for the codec ADC path, clocked by aud_bclk.
// Captures MSB-first words after each aud_lrc edge and pairs left/right words into frames.
module audio_receive #(
  parameter logic [5:0] WL = 6'd32
) (
  input  logic        aud_bclk,
  input  logic        rst,
  input  logic        aud_lrc,
  input  logic        aud_adcdat,
  output logic [31:0] adc_data,
  output logic        adc_chan,
  output logic        rx_done,
  output logic [31:0] adc_data_l,
  output logic [31:0] adc_data_r,
  output logic        frame_valid,
  output logic        short_err
);

  typedef enum logic [1:0] {SYNC, RECV, DONE} state_t;

  localparam logic [5:0] SHAMT = 6'd32 - WL;

  state_t      state, state_nxt;
  logic        lrc_d0;
  logic        lrc_edge;
  logic [5:0]  rx_cnt;
  logic [30:0] shift;
  logic        cur_chan;
  logic [31:0] l_hold;
  logic        l_ok;
  logic        restart, capture, word_end, short_word;
  logic [31:0] word_full;

  assign lrc_edge  = aud_lrc ^ lrc_d0;
  // Bits above the word length are zero because the shifter is cleared on every restart.
  assign word_full = {shift, aud_adcdat} << SHAMT;

  always_ff @(posedge aud_bclk) begin
    if (rst) state <= SYNC;
    else     state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    restart    = 1'b0;
    capture    = 1'b0;
    word_end   = 1'b0;
    short_word = 1'b0;
    case (state)
      SYNC: begin
        if (lrc_edge) begin
          restart   = 1'b1;
          state_nxt = RECV;
        end
      end
      RECV: begin
        // An lrc edge always wins, even on the cycle that would have completed the word.
        if (lrc_edge) begin
          restart    = 1'b1;
          short_word = 1'b1;
        end else begin
          capture = 1'b1;
          if (rx_cnt == WL - 6'd1) begin
            word_end  = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (lrc_edge) begin
          restart   = 1'b1;
          state_nxt = RECV;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aud_bclk) begin
    if (rst) begin
      // NOTE: lrc_d0 loads the live lrc level so the first cycle after reset sees no false edge.
      lrc_d0      <= aud_lrc;
      rx_cnt      <= '0;
      shift       <= '0;
      cur_chan    <= 1'b0;
      l_hold      <= '0;
      l_ok        <= 1'b0;
      adc_data    <= '0;
      adc_chan    <= 1'b0;
      rx_done     <= 1'b0;
      adc_data_l  <= '0;
      adc_data_r  <= '0;
      frame_valid <= 1'b0;
      short_err   <= 1'b0;
    end else begin
      lrc_d0      <= aud_lrc;
      rx_done     <= word_end;
      short_err   <= short_word;
      frame_valid <= 1'b0;

      if (restart) begin
        rx_cnt   <= '0;
        shift    <= '0;
        cur_chan <= aud_lrc;
      end else if (capture) begin
        shift  <= {shift[29:0], aud_adcdat};
        rx_cnt <= rx_cnt + 6'd1;
      end

      if (word_end) begin
        adc_data <= word_full;
        adc_chan <= cur_chan;
        if (!cur_chan) begin
          l_hold <= word_full;
          l_ok   <= 1'b1;
        end
      end

      // The right word is still on adc_data in the cycle its rx_done is high.
      if (rx_done && adc_chan && l_ok) begin
        adc_data_l  <= l_hold;
        adc_data_r  <= adc_data;
        frame_valid <= 1'b1;
        l_ok        <= 1'b0;
      end

      if (short_word) l_ok <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_receive.sv
// Directed bench for audio_receive: WL=32 and WL=24 instances share one I2S stimulus stream.
// A passive monitor records pulses; the directed sequence compares against hand-computed values.
module tb_audio_receive;

  logic clk = 1'b0;
  logic rst, lrc, dat;

  logic [31:0] data32, l32, r32, data24, l24, r24;
  logic        chan32, done32, frame32, short32;
  logic        chan24, done24, frame24, short24;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  audio_receive #(.WL(6'd32)) u32 (
    .aud_bclk(clk), .rst(rst), .aud_lrc(lrc), .aud_adcdat(dat),
    .adc_data(data32), .adc_chan(chan32), .rx_done(done32),
    .adc_data_l(l32), .adc_data_r(r32), .frame_valid(frame32), .short_err(short32)
  );

  audio_receive #(.WL(6'd24)) u24 (
    .aud_bclk(clk), .rst(rst), .aud_lrc(lrc), .aud_adcdat(dat),
    .adc_data(data24), .adc_chan(chan24), .rx_done(done24),
    .adc_data_l(l24), .adc_data_r(r24), .frame_valid(frame24), .short_err(short24)
  );

  // Pulse monitor, sampled 2 time units after each rising edge.
  logic [31:0] dq[$];
  logic        cq[$];
  int cyc = 0, done_cyc = 0, frame_cyc = 0;
  int n_short32 = 0, n_frame32 = 0, n_frame24 = 0, n_short24 = 0, n_done24 = 0;

  always begin
    @(posedge clk);
    #2;
    cyc++;
    if (done32) begin
      dq.push_back(data32);
      cq.push_back(chan32);
      done_cyc = cyc;
    end
    if (short32) n_short32++;
    if (frame32) begin
      n_frame32++;
      frame_cyc = cyc;
    end
    if (done24)  n_done24++;
    if (frame24) n_frame24++;
    if (short24) n_short24++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One slot: lrc set on a falling edge, then slot bits MSB-first on following falling edges.
  task automatic send_bits(input logic ch, input logic [31:0] bits, input int n);
    @(negedge clk);
    lrc = ch;
    dat = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dat = bits[31-i];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dat = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"},  data32, 32'h0);
    check({tag, "_chan"},  32'(chan32), 32'h0);
    check({tag, "_done"},  32'(done32), 32'h0);
    check({tag, "_l"},     l32, 32'h0);
    check({tag, "_r"},     r32, 32'h0);
    check({tag, "_frame"}, 32'(frame32), 32'h0);
    check({tag, "_short"}, 32'(short32), 32'h0);
  endtask

  int b_done, b_short, b_frame, b_frame24, b_short24, b_done24;
  logic [31:0] word;

  task automatic snap();
    b_done    = dq.size();
    b_short   = n_short32;
    b_frame   = n_frame32;
    b_frame24 = n_frame24;
    b_short24 = n_short24;
    b_done24  = n_done24;
  endtask

  initial begin
    rst = 1'b1;
    lrc = 1'b1;
    dat = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_zero("reset");

    // lrc held high after reset: no false edge
    snap();
    idle(10);
    check("no_false_done",  32'(dq.size() - b_done), 32'd0);
    check("no_false_short", 32'(n_short32 - b_short), 32'd0);

    // WL=32 stereo frame
    snap();
    send_bits(1'b0, 32'hA5A5_1234, 32);
    send_bits(1'b1, 32'h0F0F_F0F0, 32);
    idle(4);
    check("f1_done_cnt", 32'(dq.size() - b_done), 32'd2);
    check("f1_l_data",   dq[b_done], 32'hA5A5_1234);
    check("f1_l_chan",   32'(cq[b_done]), 32'd0);
    check("f1_r_data",   dq[b_done+1], 32'h0F0F_F0F0);
    check("f1_r_chan",   32'(cq[b_done+1]), 32'd1);
    check("f1_frame_cnt", 32'(n_frame32 - b_frame), 32'd1);
    check("f1_frame_lag", 32'(frame_cyc - done_cyc), 32'd1);
    check("f1_l_out",    l32, 32'hA5A5_1234);
    check("f1_r_out",    r32, 32'h0F0F_F0F0);
    check("f1_short",    32'(n_short32 - b_short), 32'd0);

    // WL=24 in 32-bit slots; trailing pad bits must be ignored
    snap();
    send_bits(1'b0, {24'h800001, 8'hA5}, 32);
    send_bits(1'b1, {24'h7FFFFF, 8'h5A}, 32);
    idle(4);
    check("w24_done_cnt",  32'(n_done24 - b_done24), 32'd2);
    check("w24_frame_cnt", 32'(n_frame24 - b_frame24), 32'd1);
    check("w24_l_out",     l24, 32'h8000_0100);
    check("w24_r_out",     r24, 32'h7FFF_FF00);
    check("w24_short",     32'(n_short24 - b_short24), 32'd0);

    // Short left word (20 bits), then a full right word: no frame
    snap();
    send_bits(1'b0, 32'hDEAD_BEEF, 20);
    send_bits(1'b1, 32'h1234_5678, 32);
    idle(4);
    check("sh_short_cnt", 32'(n_short32 - b_short), 32'd1);
    check("sh_done_cnt",  32'(dq.size() - b_done), 32'd1);
    check("sh_r_data",    dq[b_done], 32'h1234_5678);
    check("sh_r_chan",    32'(cq[b_done]), 32'd1);
    check("sh_no_frame",  32'(n_frame32 - b_frame), 32'd0);

    // Next full pair recovers
    snap();
    send_bits(1'b0, 32'h1111_2222, 32);
    send_bits(1'b1, 32'h3333_4444, 32);
    idle(4);
    check("rec_frame_cnt", 32'(n_frame32 - b_frame), 32'd1);
    check("rec_l_out",     l32, 32'h1111_2222);
    check("rec_r_out",     r32, 32'h3333_4444);

    // Reset at bit 10 of a right word
    send_bits(1'b0, 32'hCAFE_F00D, 32);
    word = 32'h5555_AAAA;
    @(negedge clk);
    lrc = 1'b1;
    dat = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dat = word[31-i];
    end
    @(negedge clk);
    dat = word[21];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("midrst");
    snap();
    for (int i = 11; i < 32; i++) begin
      dat = word[31-i];
      @(negedge clk);
    end
    idle(4);
    check("midrst_no_done",  32'(dq.size() - b_done), 32'd0);
    check("midrst_no_short", 32'(n_short32 - b_short), 32'd0);
    check("midrst_no_frame", 32'(n_frame32 - b_frame), 32'd0);
    send_bits(1'b0, 32'h0BAD_CAFE, 32);
    send_bits(1'b1, 32'h600D_F00D, 32);
    idle(4);
    check("midrst_frame_cnt", 32'(n_frame32 - b_frame), 32'd1);
    check("midrst_l_out",     l32, 32'h0BAD_CAFE);
    check("midrst_r_out",     r32, 32'h600D_F00D);

    // lrc edge on the cycle rx_cnt == 31: short word, no rx_done for it
    snap();
    send_bits(1'b0, 32'hFFFF_FFFF, 31);
    send_bits(1'b1, 32'h8765_4321, 32);
    idle(4);
    check("c31_short_cnt", 32'(n_short32 - b_short), 32'd1);
    check("c31_done_cnt",  32'(dq.size() - b_done), 32'd1);
    check("c31_r_chan",    32'(cq[b_done]), 32'd1);
    check("c31_r_data",    dq[b_done], 32'h8765_4321);
    check("c31_no_frame",  32'(n_frame32 - b_frame), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_receive.md
Name: audio_receive

Overview:
- I2S serial-to-parallel receiver for the codec ADC path. It is the capture-side counterpart of the DAC serializer.
- Runs entirely in the aud_bclk domain. Samples aud_adcdat MSB-first after each aud_lrc transition.
- Presents each word MSB-aligned in 32 bits with a one-cycle done pulse, plus a stereo pair with a frame strobe.
- Flags short words, i.e. an aud_lrc edge arriving before WL bits have been captured.

Parameters:
- WL, 6'd32: word length in bits. Legal range 8..32.

Ports:
- aud_bclk  input  1  codec bit clock; sole clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- aud_lrc  input  1  word select; 0 = left, 1 = right
- aud_adcdat  input  1  serial ADC data; codec changes it on falling aud_bclk
- adc_data  output  32  last completed word, MSB-aligned, low (32-WL) bits zero
- adc_chan  output  1  channel of adc_data (aud_lrc level at that word's start)
- rx_done  output  1  one-cycle pulse: adc_data/adc_chan updated
- adc_data_l  output  32  last left word of a complete frame
- adc_data_r  output  32  last right word of a complete frame
- frame_valid  output  1  one-cycle pulse: adc_data_l/adc_data_r updated as a pair
- short_err  output  1  one-cycle pulse: word truncated by an early aud_lrc edge

Behaviour:
- Reset (rst high at a rising edge):
  - All outputs go to 0; shift register, rx_cnt and left holding register are cleared.
  - lrc_d0 loads aud_lrc, not 0, so no false edge is seen on the first cycle after reset.
  - State goes to SYNC.
  - Reset applied mid-word discards the partial word; no pulse is generated.
- Edge detect: lrc_edge = aud_lrc XOR lrc_d0. lrc_d0 <= aud_lrc every cycle.
- rx_cnt: 6 bits; the number of bits captured in the current word.
- State SYNC:
  - aud_adcdat is ignored.
  - On lrc_edge: go to RECV, rx_cnt <= 0, latch cur_chan <= aud_lrc, clear the shift register.
  - No short_err is ever raised from SYNC.
- State RECV, no lrc_edge:
  - Shift register <= {shift[30:0], aud_adcdat}; rx_cnt <= rx_cnt+1.
  - Bit k after the edge (k = rx_cnt) is the word's bit WL-1-k; this matches a transmitter driving bit WL-1 on the falling edge after the lrc edge (one-bit I2S delay).
  - When rx_cnt == WL-1, on that same edge:
    - adc_data <= ({shift[WL-2:0], aud_adcdat}) << (32-WL)
    - adc_chan <= cur_chan
    - rx_done <= 1
    - go to DONE
- State RECV, lrc_edge with rx_cnt < WL:
  - short_err <= 1 and the partial word is discarded.
  - Restart as for SYNC: rx_cnt <= 0, cur_chan <= aud_lrc, stay in RECV.
  - A pending left word is invalidated (no frame_valid for this frame).
- State DONE:
  - aud_adcdat is ignored; rx_cnt holds at WL.
  - On lrc_edge: rx_cnt <= 0, latch cur_chan, go to RECV. No error.
- Stereo pairing:
  - Completed left word (cur_chan = 0): copied to l_hold and l_ok set.
  - Completed right word with l_ok = 1 (registered one cycle after rx_done):
    - adc_data_l <= l_hold
    - adc_data_r <= that right word
    - frame_valid <= 1 for exactly one cycle, one cycle after the right word's rx_done
    - l_ok cleared
  - A right word without l_ok updates adc_data only; frame_valid is not pulsed.
- Pulse rules: rx_done, frame_valid and short_err are all single-cycle, and are 0 in any cycle where their condition does not hold.
- Simultaneous lrc_edge and rx_cnt == WL-1:
  - The edge wins: treated as a short word, short_err pulses, no rx_done.
  - A full word needs WL bit-clock sampling edges before the next lrc edge.
- Slot longer than WL (e.g. 32-bit slots, WL = 24): extra bits are ignored in DONE.

Test Plan:
- Reset, then aud_lrc held 1 for 10 cycles -> no rx_done and no short_err (no false edge, still in SYNC).
- WL = 32, I2S stimulus: left 0xA5A5_1234, right 0x0F0F_F0F0 -> rx_done with adc_chan = 0 and adc_data 0xA5A51234; rx_done with adc_chan = 1 and adc_data 0x0F0FF0F0; frame_valid one cycle later with adc_data_l/adc_data_r equal to those values.
- WL = 24, 32-bit slots, left 0x800001, right 0x7FFFFF -> adc_data_l = 0x80000100, adc_data_r = 0x7FFFFF00; trailing 8 bits per slot ignored, short_err stays 0.
- WL = 32, lrc toggled after 20 bits of a left word, followed by a full right word -> short_err pulse; right word produces rx_done; no frame_valid; the next full L/R pair gives frame_valid.
- rst asserted for one cycle at bit 10 of a right word -> all outputs 0, no pulses; receiver resyncs on the next lrc edge and the following full frame gives frame_valid.
- lrc edge on the cycle rx_cnt == 31 (WL = 32) -> short_err = 1, rx_done = 0.
